pipeline_register: RTL



---
 rtl/pipeline_register.sv | 107 ++++++++++
 1 files changed

// File: rtl/pipeline_register.sv
// pipeline_register: P_STAGES-deep register pipeline with valid/ready flow control.
//
// Beats enter at stage 0 and move one stage towards the output per enabled edge.
// A stage is loaded whenever it is empty or its successor is being loaded, so
// interior bubbles collapse under backpressure and a full pipeline streams one
// beat per cycle when I_READY is held high.
//
// Ports:
//   I_CLK     rising-edge clock
//   I_NRESET  asynchronous active-low reset (clears all valid and data state)
//   I_ENABLE  global enable; low freezes the pipeline and blocks both handshakes
//   I_FLUSH   synchronous flush; empties every stage on the next edge
//   I_VALID   upstream beat valid
//   O_READY   block accepts a beat this cycle
//   I_DATA    upstream beat data
//   O_VALID   downstream beat valid
//   I_READY   downstream accepts a beat
//   O_DATA    downstream beat data (output stage contents, shown even when invalid)
//   O_COUNT   number of occupied stages
module pipeline_register #(
  parameter int unsigned P_WIDTH  = 16,
  parameter int unsigned P_STAGES = 2
) (
  input  logic                            I_CLK,
  input  logic                            I_NRESET,
  input  logic                            I_ENABLE,
  input  logic                            I_FLUSH,
  input  logic                            I_VALID,
  output logic                            O_READY,
  input  logic [P_WIDTH-1:0]              I_DATA,
  output logic                            O_VALID,
  input  logic                            I_READY,
  output logic [P_WIDTH-1:0]              O_DATA,
  output logic [$clog2(P_STAGES+1)-1:0]   O_COUNT
);

  localparam int unsigned CountW = $clog2(P_STAGES + 1);
  localparam int          NumSt  = int'(P_STAGES);

  logic [P_STAGES-1:0] valid_q, valid_d;
  logic [P_WIDTH-1:0]  data_q [P_STAGES];
  logic [P_WIDTH-1:0]  data_d [P_STAGES];

  // stage_ready[k]: stage k may be overwritten this cycle. Index P_STAGES is the
  // downstream consumer.
  logic [P_STAGES:0]   stage_ready;
  logic [CountW-1:0]   count;

  // Readiness ripples from the output side back to the input side.
  always_comb begin
    logic [P_STAGES:0] rdy;
    rdy           = '0;
    rdy[P_STAGES] = I_READY;
    for (int k = NumSt - 1; k >= 0; k--) begin
      rdy[k] = ~valid_q[k] | rdy[k+1];
    end
    stage_ready = rdy;
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (I_FLUSH) begin
      // Flush wins over enable; data contents are left as they are.
      valid_d = '0;
    end else if (I_ENABLE) begin
      for (int k = 1; k < NumSt; k++) begin
        if (stage_ready[k]) begin
          valid_d[k] = valid_q[k-1];
          // Data only moves with a real beat; a bubble leaves stale data behind.
          if (valid_q[k-1]) begin
            data_d[k] = data_q[k-1];
          end
        end
      end
      if (stage_ready[0]) begin
        valid_d[0] = I_VALID;
        if (I_VALID) begin
          data_d[0] = I_DATA;
        end
      end
    end
  end

  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      valid_q <= '0;
      data_q  <= '{default: '0};
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    count = '0;
    for (int k = 0; k < NumSt; k++) begin
      count = count + CountW'(valid_q[k]);
    end
  end

  assign O_READY = stage_ready[0] & I_ENABLE & ~I_FLUSH;
  assign O_VALID = valid_q[P_STAGES-1] & I_ENABLE;
  assign O_DATA  = data_q[P_STAGES-1];
  assign O_COUNT = count;

endmodule
